// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed 9-tap symmetric FIR controller: one multiplier and one
// add16se_EMB adder are shared across all taps over an 8-cycle MAC sequence.
module fir_mac_sequencer #(
  parameter logic [15:0] C0        = 16'd32,
  parameter logic [15:0] C1        = 16'd18,
  parameter logic [15:0] C2        = 16'd6,
  parameter logic [15:0] C3        = 16'd0,
  parameter logic [15:0] C4        = 16'd2,
  parameter bit          EXACT_ADD = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] y,
  output logic        busy
);

  localparam int unsigned DW    = 16;
  localparam int unsigned TAPS  = 9;
  localparam int unsigned PW    = 4;
  localparam int unsigned LOW_W = 4;
  localparam int unsigned HI_W  = DW - LOW_W;

  localparam logic [PW-1:0] LAST_IDX = PW'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // add16se_EMB: lower-part-OR approximate adder. The low LOW_W bits are ORed,
  // the AND of the top low-part bits is the carry into an exact upper adder.
  function automatic logic [DW-1:0] add16se_emb(input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
    logic [HI_W-1:0] hi;
    hi = a[DW-1:LOW_W] + b[DW-1:LOW_W] + HI_W'(a[LOW_W-1] & b[LOW_W-1]);
    return {hi, a[LOW_W-1:0] | b[LOW_W-1:0]};
  endfunction

  function automatic logic [DW-1:0] tap_coef(input logic [PW-1:0] k);
    logic [DW-1:0] c;
    case (k)
      4'd0, 4'd8: c = C0;
      4'd1, 4'd7: c = C1;
      4'd2, 4'd6: c = C2;
      4'd3, 4'd5: c = C3;
      4'd4:       c = DW'(-C4);
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_e         state_q, state_d;
  logic [DW-1:0]  hist_q [TAPS];
  logic [DW-1:0]  hist_d [TAPS];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  tap_q, tap_d;
  logic [DW-1:0]  acc_q, acc_d;
  logic [DW-1:0]  y_q, y_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;

  logic [PW-1:0]  newest_idx;
  logic [PW-1:0]  rd_idx;
  logic [DW-1:0]  mul_coef;
  logic [DW-1:0]  mul_smp;
  logic [DW-1:0]  prod;
  logic [DW-1:0]  add_a;
  logic [DW-1:0]  add_b;
  logic [DW-1:0]  sum;

  // History slot holding the sample accepted tap_q accepts ago.
  always_comb begin : rd_addr
    newest_idx = (wr_ptr_q == '0) ? LAST_IDX : wr_ptr_q - PW'(1);
    if (newest_idx >= tap_q) begin
      rd_idx = newest_idx - tap_q;
    end else begin
      rd_idx = (PW'(TAPS) - tap_q) + newest_idx;
    end
  end

  // In IDLE the idle multiplier precomputes tap 0 from the incoming sample.
  always_comb begin : mul_operands
    mul_coef = tap_coef(tap_q);
    mul_smp  = hist_q[rd_idx];
    if (state_q == IDLE) begin
      mul_coef = C0;
      mul_smp  = x;
    end
  end

  // Low 16 bits of an unsigned product equal those of the signed product.
  assign prod = mul_coef * mul_smp;
  assign sum  = EXACT_ADD ? (add_a + add_b) : add16se_emb(add_a, add_b);

  always_comb begin : next_state
    state_d     = state_q;
    hist_d      = hist_q;
    wr_ptr_d    = wr_ptr_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    add_a       = prod;
    add_b       = acc_q;

    case (state_q)
      IDLE: begin
        if (flush) begin
          hist_d   = '{default: '0};
          wr_ptr_d = '0;
        end else if (in_valid) begin
          hist_d[wr_ptr_q] = x;
          wr_ptr_d         = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PW'(1);
          acc_d            = prod;
          tap_d            = PW'(1);
          state_d          = MAC;
        end
      end
      MAC: begin
        // First step keeps the unrolled chain order: A = p0 (held in acc), B = p1.
        if (tap_q == PW'(1)) begin
          add_a = acc_q;
          add_b = prod;
        end
        acc_d = sum;
        if (tap_q == LAST_IDX) begin
          tap_d   = '0;
          state_d = OUT;
        end else begin
          tap_d = tap_q + PW'(1);
        end
      end
      OUT: begin
        if (!out_valid_q) begin
          y_d         = acc_q;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state_q     <= IDLE;
      hist_q      <= '{default: '0};
      wr_ptr_q    <= '0;
      tap_q       <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      wr_ptr_q    <= wr_ptr_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // A simultaneous flush must block acceptance in the same cycle.
  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: exact and approximate instances share stimulus
// and are checked against a newest-first history model of the unrolled FIR.
module tb_fir_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] x;

  logic        in_ready_e, out_valid_e, busy_e;
  logic [15:0] y_e;
  logic        in_ready_a, out_valid_a, busy_a;
  logic [15:0] y_a;

  int          n_checks = 0;
  int          n_fails  = 0;

  logic [15:0] mhist [9];
  int          coefs [9] = '{32, 18, 6, 0, -2, 0, 6, 18, 32};
  logic [15:0] imp_x   [10] = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
  logic [15:0] imp_exp [10] = '{16'd32, 16'd18, 16'd6, 16'd0, 16'hFFFE, 16'd0, 16'd6, 16'd18, 16'd32, 16'd0};
  logic [15:0] stp_exp [10] = '{16'd32, 16'd50, 16'd56, 16'd56, 16'd54, 16'd54, 16'd60, 16'd78, 16'd110, 16'd110};
  logic [15:0] last_y;
  logic [15:0] held_y;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.EXACT_ADD(1'b1)) u_exact (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_e),
    .x(x), .out_valid(out_valid_e), .out_ready(out_ready), .y(y_e), .busy(busy_e)
  );

  fir_mac_sequencer #(.EXACT_ADD(1'b0)) u_approx (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .x(x), .out_valid(out_valid_a), .out_ready(out_ready), .y(y_a), .busy(busy_a)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 9; k++) mhist[k] = 16'd0;
  endfunction

  function automatic void model_push(input logic [15:0] s);
    for (int k = 8; k > 0; k--) mhist[k] = mhist[k-1];
    mhist[0] = s;
  endfunction

  function automatic logic [15:0] tap_prod(input int k);
    int p;
    p = coefs[k] * int'($signed(mhist[k]));
    return p[15:0];
  endfunction

  // Lower-part-OR adder: OR of 4 low bits, carry = AND of bit 3, exact 12-bit upper sum.
  function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b, input bit exact);
    int ai, bi, lo, hi, r;
    ai = int'(a);
    bi = int'(b);
    if (exact) begin
      r = (ai + bi) % 65536;
    end else begin
      lo = (ai | bi) % 16;
      hi = ((ai / 16) + (bi / 16) + (((ai / 8) % 2) & ((bi / 8) % 2))) % 4096;
      r  = hi * 16 + lo;
    end
    return r[15:0];
  endfunction

  function automatic logic [15:0] model_y(input bit exact);
    logic [15:0] acc;
    acc = model_add(tap_prod(0), tap_prod(1), exact);
    for (int k = 2; k < 9; k++) acc = model_add(tap_prod(k), acc, exact);
    return acc;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  task automatic present(input logic [15:0] s);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready_e && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_accept", 16'(in_ready_e), 16'd1);
    x        = s;
    in_valid = 1'b1;
    @(posedge clk);
    model_push(s);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [15:0] ye);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid_e && n < 40);
    check("latency", 16'(n), 16'd10);
    check("out_valid_exact", 16'(out_valid_e), 16'd1);
    check("out_valid_approx", 16'(out_valid_a), 16'd1);
    check("busy_in_out", 16'(busy_e), 16'd1);
    check("y_exact_model", y_e, model_y(1'b1));
    check("y_approx_model", y_a, model_y(1'b0));
    ye = y_e;
    if (out_ready) begin
      @(negedge clk);
      check("out_valid_drop", 16'(out_valid_e), 16'd0);
      check("in_ready_back", 16'(in_ready_e), 16'd1);
      check("busy_drop", 16'(busy_a), 16'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = 16'd0;
    do_reset();

    @(negedge clk);
    check("rst_out_valid", 16'(out_valid_e), 16'd0);
    check("rst_in_ready", 16'(in_ready_e), 16'd1);
    check("rst_busy", 16'(busy_e), 16'd0);
    check("rst_y", y_e, 16'd0);

    // Impulse response, then step response on top of the cleared history.
    for (int i = 0; i < 10; i++) begin
      present(imp_x[i]);
      wait_result(last_y);
      check("impulse_y", last_y, imp_exp[i]);
    end
    for (int i = 0; i < 10; i++) begin
      present(16'd1);
      wait_result(last_y);
      check("step_y", last_y, stp_exp[i]);
    end

    // Flush with a simultaneous sample: flush wins and the sample is dropped.
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    x        = 16'd7;
    #1 check("flush_blocks_ready", 16'(in_ready_e), 16'd0);
    @(posedge clk);
    #1 begin
      flush    = 1'b0;
      in_valid = 1'b0;
    end
    model_clear();
    present(16'd0);
    wait_result(last_y);
    check("after_flush_y", last_y, 16'd0);

    // Product truncation and sum wrap.
    do_reset();
    present(16'd1024);
    wait_result(last_y);
    check("wrap_8000", last_y, 16'h8000);
    present(16'h1000);
    wait_result(last_y);
    check("trunc_18432", last_y, 16'd18432);

    // Backpressure: result held for 20 cycles while a sample is pending.
    out_ready = 1'b0;
    present(16'd3);
    wait_result(held_y);
    in_valid = 1'b1;
    x        = 16'd9;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_y_stable", y_e, held_y);
      check("bp_out_valid", 16'(out_valid_e), 16'd1);
      check("bp_in_ready", 16'(in_ready_e), 16'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid", 16'(out_valid_e), 16'd0);
    check("bp_release_ready", 16'(in_ready_e), 16'd1);
    @(posedge clk);
    model_push(16'd9);
    #1 in_valid = 1'b0;
    wait_result(last_y);

    // Reset during MAC at tap 4 discards the pending result and history.
    present(16'd5);
    repeat (4) @(negedge clk);
    check("mid_mac_busy", 16'(busy_e), 16'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    @(negedge clk);
    check("mac_rst_out_valid", 16'(out_valid_e), 16'd0);
    check("mac_rst_in_ready", 16'(in_ready_e), 16'd1);
    check("mac_rst_busy", 16'(busy_e), 16'd0);
    for (int i = 0; i < 10; i++) begin
      present(imp_x[i]);
      wait_result(last_y);
      check("impulse2_y", last_y, imp_exp[i]);
    end

    // Random samples against the reference chain for both adder modes.
    for (int i = 0; i < 1000; i++) begin
      present(16'($urandom));
      wait_result(last_y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
